// File: rtl/sd_arb_pkg.sv
// Shared constants for the SD SPI-bus arbiter: FSM state codes, owner codes and the default gap length.
package sd_arb_pkg;

    typedef logic [1:0] owner_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam owner_t OWN_NONE  = 2'd0;
    localparam owner_t OWN_INIT  = 2'd1;
    localparam owner_t OWN_READ  = 2'd2;
    localparam owner_t OWN_WRITE = 2'd3;

    localparam int GAP_CYCLES_DEF = 8;

endpackage

// File: rtl/sd_arb_rr.sv
// Two-way round-robin picker between sd_read and sd_write; ptr_i=0 favours read on a tie.
module sd_arb_rr (
    input  logic rd_req_i,
    input  logic wr_req_i,
    input  logic ptr_i,
    output logic pick_rd_o,
    output logic pick_wr_o,
    output logic ptr_nxt_o
);

    assign pick_rd_o = rd_req_i & (~wr_req_i | ~ptr_i);
    assign pick_wr_o = wr_req_i & (~rd_req_i |  ptr_i);

    // Any grant hands priority to the other engine.
    assign ptr_nxt_o = pick_rd_o ? 1'b1 : (pick_wr_o ? 1'b0 : ptr_i);

endmodule

// File: rtl/sd_bus_arbiter.sv
// Shares the SD chip-select/MOSI pins between init, read and write engines with a CS-high gap after each release.
// Optional ownership timeout with requester lock-out is enabled by defining SD_ARB_TIMEOUT_EN.
module sd_bus_arbiter
    import sd_arb_pkg::*;
#(
    parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_done,
    input  logic       init_req,
    input  logic       init_cs,
    input  logic       init_mosi,
    input  logic       rd_req,
    input  logic       rd_cs,
    input  logic       rd_mosi,
    input  logic       wr_req,
    input  logic       wr_cs,
    input  logic       wr_mosi,
    output logic       init_gnt,
    output logic       rd_gnt,
    output logic       wr_gnt,
    output logic       SD_CS,
    output logic       SD_DATAIN,
    output logic [1:0] owner,
    output logic       busy,
    output logic       timeout_err
);

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    owner_t           owner_q, owner_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             owner_req;
    logic             to_hit;
    logic [2:0]       locked;
    logic             pick_rd, pick_wr, ptr_nxt;

    always_comb begin
        owner_req = 1'b0;
        case (owner_q)
            OWN_INIT:  owner_req = init_req;
            OWN_READ:  owner_req = rd_req;
            OWN_WRITE: owner_req = wr_req;
            default:   owner_req = 1'b0;
        endcase
    end

`ifdef SD_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [2:0] lock_q, lock_d;
    logic       to_err_q;

    assign to_hit = (state_q == ST_OWN) && owner_req && (cnt_q == TO_LAST);

    // A lock survives only while its requester keeps req asserted.
    always_comb begin
        lock_d = lock_q & {wr_req, rd_req, init_req};
        if (to_hit) begin
            case (owner_q)
                OWN_INIT:  lock_d[0] = 1'b1;
                OWN_READ:  lock_d[1] = 1'b1;
                OWN_WRITE: lock_d[2] = 1'b1;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q   <= '0;
            to_err_q <= 1'b0;
        end else begin
            lock_q   <= lock_d;
            to_err_q <= to_hit;
        end
    end

    assign locked      = lock_q;
    assign timeout_err = to_err_q;
`else
    logic [CNT_W-1:0] unused_timeout;
    assign unused_timeout = CNT_W'(TIMEOUT_CYCLES);
    assign to_hit         = 1'b0;
    assign locked         = '0;
    assign timeout_err    = 1'b0;
`endif

    sd_arb_rr u_rr (
        .rd_req_i  (rd_req & ~locked[1]),
        .wr_req_i  (wr_req & ~locked[2]),
        .ptr_i     (rr_ptr_q),
        .pick_rd_o (pick_rd),
        .pick_wr_o (pick_wr),
        .ptr_nxt_o (ptr_nxt)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!init_done) begin
                    if (init_req && !locked[0]) begin
                        state_d = ST_OWN;
                        owner_d = OWN_INIT;
                        cnt_d   = '0;
                    end
                end else if (pick_rd || pick_wr) begin
                    state_d  = ST_OWN;
                    owner_d  = pick_rd ? OWN_READ : OWN_WRITE;
                    rr_ptr_d = ptr_nxt;
                    cnt_d    = '0;
                end
            end
            ST_OWN: begin
                if (!owner_req || to_hit) begin
                    state_d = ST_GAP;
                    owner_d = OWN_NONE;
                    cnt_d   = GAP_LAST;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CNT_ONE;
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_NONE;
            rr_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // owner_q is OWN_NONE outside OWN, so the pins idle high in IDLE and GAP.
    always_comb begin
        SD_CS     = 1'b1;
        SD_DATAIN = 1'b1;
        case (owner_q)
            OWN_INIT:  begin SD_CS = init_cs; SD_DATAIN = init_mosi; end
            OWN_READ:  begin SD_CS = rd_cs;   SD_DATAIN = rd_mosi;   end
            OWN_WRITE: begin SD_CS = wr_cs;   SD_DATAIN = wr_mosi;   end
            default:   ;
        endcase
    end

    assign init_gnt = (owner_q == OWN_INIT);
    assign rd_gnt   = (owner_q == OWN_READ);
    assign wr_gnt   = (owner_q == OWN_WRITE);
    assign owner    = owner_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sd_bus_arbiter.sv
// Directed bench for sd_bus_arbiter: table-driven pin-mux vectors plus hand sequences for ordering, gap, reset and timeout.
module tb_sd_bus_arbiter;
    import sd_arb_pkg::*;

    localparam int GAP = 8;
    localparam int TO  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init_done = 1'b0;
    logic       init_req = 1'b0, init_cs = 1'b1, init_mosi = 1'b1;
    logic       rd_req = 1'b0, rd_cs = 1'b1, rd_mosi = 1'b1;
    logic       wr_req = 1'b0, wr_cs = 1'b1, wr_mosi = 1'b1;
    logic       init_gnt, rd_gnt, wr_gnt, SD_CS, SD_DATAIN, busy, timeout_err;
    logic [1:0] owner;

    sd_bus_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .init_req(init_req), .init_cs(init_cs), .init_mosi(init_mosi),
        .rd_req(rd_req), .rd_cs(rd_cs), .rd_mosi(rd_mosi),
        .wr_req(wr_req), .wr_cs(wr_cs), .wr_mosi(wr_mosi),
        .init_gnt(init_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt),
        .SD_CS(SD_CS), .SD_DATAIN(SD_DATAIN), .owner(owner),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic rd_cs, rd_mosi, wr_cs, wr_mosi, init_cs, init_mosi, exp_cs, exp_din;
    } vec_t;
    vec_t tbl[8];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("gnt_onehot", 32'($countones({init_gnt, rd_gnt, wr_gnt}) <= 1), 1);
    endtask

    // Counts GAP samples (busy, pins high) and IDLE samples until someone owns the bus.
    task automatic gap_then(input logic [1:0] exp_owner, input string nm);
        int g;
        int idl;
        g = 0;
        idl = 0;
        for (int k = 0; k < 40 && owner == OWN_NONE; k++) begin
            if (busy && SD_CS && SD_DATAIN) g++;
            else if (!busy) idl++;
            tick();
        end
        chk({nm, "_gap_len"}, g, GAP);
        chk({nm, "_idle_len"}, idl, 1);
        chk({nm, "_owner"}, {30'd0, owner}, {30'd0, exp_owner});
    endtask

    task automatic wait_idle(input string nm);
        for (int k = 0; k < 40 && busy; k++) tick();
        chk(nm, {31'd0, busy}, 0);
    endtask

    initial begin
        int gc, pc, regrant;
        bit seen_low;

        // Read engine streams 0xA5 on MOSI while write/init inputs carry noise.
        tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        #12;
        chk("rst_gnts",  {29'd0, init_gnt, rd_gnt, wr_gnt}, 0);
        chk("rst_owner", {30'd0, owner}, 0);
        chk("rst_busy",  {31'd0, busy}, 0);
        chk("rst_toerr", {31'd0, timeout_err}, 0);
        chk("rst_cs",    {31'd0, SD_CS}, 1);
        chk("rst_din",   {31'd0, SD_DATAIN}, 1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Before init_done only the init engine may own the bus.
        init_req = 1'b1;
        rd_req   = 1'b1;
        tick();
        chk("t1_init_gnt", {31'd0, init_gnt}, 1);
        chk("t1_rd_gnt",   {31'd0, rd_gnt}, 0);
        chk("t1_owner",    {30'd0, owner}, OWN_INIT);
        init_cs   = 1'b0;
        init_mosi = 1'b0;
        #1;
        chk("t1_init_cs",  {31'd0, SD_CS}, 0);
        chk("t1_init_din", {31'd0, SD_DATAIN}, 0);
        init_done = 1'b1;
        repeat (3) tick();
        chk("t1_hold_owner", {30'd0, owner}, OWN_INIT);
        chk("t1_hold_rd",    {31'd0, rd_gnt}, 0);
        init_req  = 1'b0;
        init_cs   = 1'b1;
        init_mosi = 1'b1;
        tick();
        gap_then(OWN_READ, "t1");
        chk("t1_rd_gnt_after", {31'd0, rd_gnt}, 1);

        // Pin mux follows the read engine bit-exact in the same cycle.
        for (int i = 0; i < 8; i++) begin
            rd_cs     = tbl[i].rd_cs;
            rd_mosi   = tbl[i].rd_mosi;
            wr_cs     = tbl[i].wr_cs;
            wr_mosi   = tbl[i].wr_mosi;
            init_cs   = tbl[i].init_cs;
            init_mosi = tbl[i].init_mosi;
            #1;
            chk($sformatf("t3_cs[%0d]", i),  {31'd0, SD_CS},     {31'd0, tbl[i].exp_cs});
            chk($sformatf("t3_din[%0d]", i), {31'd0, SD_DATAIN}, {31'd0, tbl[i].exp_din});
            tick();
        end
        {rd_cs, rd_mosi, wr_cs, wr_mosi, init_cs, init_mosi} = 6'b111111;

        // Immediate re-request still pays the whole gap.
        rd_req = 1'b0;
        tick();
        rd_req = 1'b1;
        gap_then(OWN_READ, "t4");

        // Hand the bus to write, then reset asynchronously mid-transfer.
        rd_req = 1'b0;
        wr_req = 1'b1;
        tick();
        gap_then(OWN_WRITE, "t5_pre");
        wr_cs   = 1'b0;
        wr_mosi = 1'b0;
        #1;
        chk("t5_wr_cs", {31'd0, SD_CS}, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_cs",    {31'd0, SD_CS}, 1);
        chk("t5_rst_din",   {31'd0, SD_DATAIN}, 1);
        chk("t5_rst_wrgnt", {31'd0, wr_gnt}, 0);
        chk("t5_rst_owner", {30'd0, owner}, 0);
        chk("t5_rst_busy",  {31'd0, busy}, 0);
        wr_req  = 1'b0;
        wr_cs   = 1'b1;
        wr_mosi = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Round-robin: pointer restarts at read after reset.
        rd_req = 1'b1;
        wr_req = 1'b1;
        tick();
        chk("t2_first_owner", {30'd0, owner}, OWN_READ);
        chk("t2_first_wrgnt", {31'd0, wr_gnt}, 0);
        rd_req = 1'b0;
        tick();
        gap_then(OWN_WRITE, "t2_second");
        wr_req = 1'b0;
        tick();
        rd_req = 1'b1;
        wr_req = 1'b1;
        gap_then(OWN_READ, "t2_third");
        chk("t2_third_wrgnt", {31'd0, wr_gnt}, 0);

        // Long write ownership: bounded when the timeout build is selected.
        rd_req = 1'b0;
        wr_req = 1'b0;
        tick();
        wait_idle("t6_idle");
        wr_req   = 1'b1;
        gc       = 0;
        pc       = 0;
        regrant  = 0;
        seen_low = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (wr_gnt) begin
                gc++;
                if (seen_low) regrant++;
            end else begin
                seen_low = 1'b1;
            end
            if (timeout_err) pc++;
        end
`ifdef SD_ARB_TIMEOUT_EN
        chk("t6_gnt_cycles", gc, TO);
        chk("t6_toerr_pulses", pc, 1);
        chk("t6_no_regrant", regrant, 0);
`else
        chk("t6_gnt_cycles", gc, 40);
        chk("t6_toerr_pulses", pc, 0);
`endif
        wr_req = 1'b0;
        tick();
        wr_req = 1'b1;
        for (int k = 0; k < 30 && !wr_gnt; k++) tick();
        chk("t6_regrant", {31'd0, wr_gnt}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
